// File: rtl/clk_track_pkg.sv
// Shared types and default constants for the slow-clock tracking blocks.
package clk_track_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int DEF_CNT_WIDTH = 27;
  localparam int DEF_TIMEOUT   = 100_000_000;

endpackage

// File: rtl/level_sync.sv
// Brings an asynchronous level into the clk domain and emits registered
// rise/fall pulses plus the combinational edge strobe they are built from.
module level_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic edge_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], level_i};
  assign edge_o    = sync_last ^ hist_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;

  // Synchronizer chain, history flop and registered edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
      hist_q <= INIT_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_last;
      rise_q <= sync_last & ~hist_q;
      fall_q <= ~sync_last & hist_q;
    end
  end

endmodule

// File: rtl/slow_clk_tracker.sv
// Tracks an external divided clock: edge ticks, half-period measurement,
// lock detection and edge-loss timeout, all in the fast clk domain.
module slow_clk_tracker
  import clk_track_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_LEVEL  = 1'b1,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int TOLERANCE   = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 slow_clk,
  output logic                 rise_tick,
  output logic                 fall_tick,
  output logic [CNT_WIDTH-1:0] half_period,
  output logic                 locked,
  output logic                 timeout
);

  localparam int                   MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] TOL_C     = CNT_WIDTH'(TOLERANCE);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [MW-1:0]        LOCK_C    = MW'(LOCK_COUNT);
  localparam logic [MW-1:0]        MATCH_ONE = MW'(1);

  // Magnitude of the difference without wrap-around.
  function automatic logic [CNT_WIDTH-1:0] abs_diff(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b);
    if (a >= b) begin
      return a - b;
    end else begin
      return b - a;
    end
  endfunction

  logic                 edge_det;
  logic                 in_tol;
  logic [MW-1:0]        match_inc;
  state_e               state_q,   state_d;
  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic [CNT_WIDTH-1:0] prev_q,    prev_d;
  logic [CNT_WIDTH-1:0] half_q,    half_d;
  logic [MW-1:0]        match_q,   match_d;
  logic                 locked_q,  locked_d;
  logic                 timeout_q, timeout_d;

  level_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .INIT_LEVEL  (INIT_LEVEL)
  ) u_level_sync (
    .clk     (clk),
    .rst     (rst),
    .level_i (slow_clk),
    .edge_o  (edge_det),
    .rise_o  (rise_tick),
    .fall_o  (fall_tick)
  );

  // A zero reference means no previous interval is available for comparison.
  assign in_tol    = (prev_q != '0) && (abs_diff(counter_q, prev_q) <= TOL_C);
  assign match_inc = match_q + MATCH_ONE;

  // Interval counter and tracking FSM next-state logic.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    prev_d    = prev_q;
    half_d    = half_q;
    match_d   = match_q;
    locked_d  = locked_q;
    timeout_d = 1'b0;

    if (edge_det) begin
      counter_d = CNT_ONE;
    end else if (counter_q != TIMEOUT_C) begin
      counter_d = counter_q + CNT_ONE;
    end else begin
      counter_d = counter_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (edge_det) begin
          state_d = ST_MEASURE;
          match_d = '0;
          prev_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (edge_det) begin
          half_d = counter_q;
          prev_d = counter_q;
          if (in_tol) begin
            match_d = match_inc;
            if (match_inc == LOCK_C) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d = ST_MEASURE;
            end
          end else begin
            match_d = '0;
          end
        end else if (counter_q == TIMEOUT_C) begin
          state_d   = ST_IDLE;
          locked_d  = 1'b0;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if (edge_det) begin
          half_d = counter_q;
          prev_d = counter_q;
          if (!in_tol) begin
            state_d  = ST_MEASURE;
            locked_d = 1'b0;
            match_d  = '0;
          end else begin
            state_d = ST_LOCKED;
          end
        end else if (counter_q == TIMEOUT_C) begin
          state_d   = ST_IDLE;
          locked_d  = 1'b0;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        locked_d = 1'b0;
        match_d  = '0;
        prev_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      counter_q <= CNT_ONE;
      prev_q    <= '0;
      half_q    <= '0;
      match_q   <= '0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      prev_q    <= prev_d;
      half_q    <= half_d;
      match_q   <= match_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign half_period = half_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_slow_clk_tracker.sv
// Randomized and directed bench for slow_clk_tracker against an
// edge-timestamp reference model.
module tb_slow_clk_tracker;

  localparam int CW  = 16;
  localparam int TO  = 64;
  localparam int TOL = 1;
  localparam int LC  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          slow_clk = 1'b1;
  logic          rise_tick;
  logic          fall_tick;
  logic [CW-1:0] half_period;
  logic          locked;
  logic          timeout;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model: edges are timestamped by the cycle they register on.
  typedef struct {
    int c;
    bit lvl;
  } pend_t;
  pend_t pq[$];
  int    last_e = 0;
  bit    m_track = 1'b0, m_locked = 1'b0, m_ref = 1'b0;
  bit    m_rise = 1'b0, m_fall = 1'b0, m_to = 1'b0;
  int    m_prev = 0, m_run = 0, m_half = 0;

  always #5 clk = ~clk;

  slow_clk_tracker #(
    .SYNC_STAGES (2),
    .INIT_LEVEL  (1'b1),
    .CNT_WIDTH   (CW),
    .TIMEOUT     (TO),
    .TOLERANCE   (TOL),
    .LOCK_COUNT  (LC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .slow_clk    (slow_clk),
    .rise_tick   (rise_tick),
    .fall_tick   (fall_tick),
    .half_period (half_period),
    .locked      (locked),
    .timeout     (timeout)
  );

  function automatic bit out_bad();
    return ({rise_tick, fall_tick, locked, timeout} !== {m_rise, m_fall, m_locked, m_to}) ||
           (half_period !== CW'(m_half));
  endfunction

  task automatic tick_cycle();
    pend_t p;
    int    iv;
    bit    ok;
    @(posedge clk);
    cyc++;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_to   = 1'b0;
    if (rst) begin
      last_e = cyc; m_track = 1'b0; m_locked = 1'b0; m_ref = 1'b0;
      m_prev = 0; m_run = 0; m_half = 0;
      pq.delete();
    end else if (pq.size() > 0 && pq[0].c == cyc) begin
      p  = pq.pop_front();
      iv = cyc - last_e;
      if (iv > TO) iv = TO;
      last_e = cyc;
      m_rise = p.lvl;
      m_fall = !p.lvl;
      if (!m_track) begin
        m_track = 1'b1; m_ref = 1'b0; m_run = 0;
      end else begin
        m_half = iv;
        ok = m_ref && (iv - m_prev <= TOL) && (m_prev - iv <= TOL);
        if (m_locked && !ok) begin
          m_locked = 1'b0; m_run = 0;
        end else if (!m_locked) begin
          m_run = ok ? m_run + 1 : 0;
          if (m_run == LC) m_locked = 1'b1;
        end
        m_prev = iv;
        m_ref  = 1'b1;
      end
    end else if (m_track && (cyc - last_e >= TO)) begin
      m_track = 1'b0; m_locked = 1'b0; m_to = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic toggle();
    slow_clk = ~slow_clk;
    pq.push_back('{cyc + 3, slow_clk});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_cycle();
      compared++;
      if ({rise_tick, fall_tick, locked, timeout, half_period} !== {4'b0000, CW'(0)}) begin
        mismatched++;
        $display("FAIL reset cyc=%0d got r%b f%b l%b t%b hp=%0d, want all zero",
                 cyc, rise_tick, fall_tick, locked, timeout, half_period);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_acq();
    int t_first = 0, t5 = 0, rise_at = -1, lock_at = -1;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) t_first = cyc;
      if (k == 4) t5 = cyc;
      toggle();
      for (int c = 0; c < 10; c++) begin
        tick_cycle();
        if ((rise_tick || fall_tick) && rise_at < 0) rise_at = cyc;
        if (locked && lock_at < 0) lock_at = cyc;
        compared++;
        if (out_bad()) begin
          mismatched++;
          $display("FAIL lock_acq cyc=%0d got r%b f%b l%b t%b hp=%0d, want r%b f%b l%b t%b hp=%0d",
                   cyc, rise_tick, fall_tick, locked, timeout, half_period,
                   m_rise, m_fall, m_locked, m_to, m_half);
        end
      end
    end
    compared++;
    if (rise_at != t_first + 3) begin
      mismatched++;
      $display("FAIL tick_latency first tick at cyc %0d, want %0d", rise_at, t_first + 3);
    end
    compared++;
    if (lock_at != t5 + 3) begin
      mismatched++;
      $display("FAIL lock_edge locked rose at cyc %0d, want %0d (5th edge)", lock_at, t5 + 3);
    end
    compared++;
    if (half_period !== CW'(10)) begin
      mismatched++;
      $display("FAIL lock_hp got %0d want 10", half_period);
    end
  endtask

  task automatic test_tolerance();
    int gaps[5] = '{10, 11, 10, 9, 10};
    for (int k = 0; k < 5; k++) begin
      toggle();
      for (int c = 0; c < gaps[k]; c++) begin
        tick_cycle();
        compared++;
        if (out_bad() || locked !== 1'b1) begin
          mismatched++;
          $display("FAIL tolerance cyc=%0d got l%b hp=%0d r%b f%b, want l%b hp=%0d r%b f%b",
                   cyc, locked, half_period, rise_tick, fall_tick,
                   m_locked, m_half, m_rise, m_fall);
        end
      end
    end
    compared++;
    if (half_period !== CW'(9)) begin
      mismatched++;
      $display("FAIL tol_hp got %0d want 9", half_period);
    end
  endtask

  task automatic test_lock_loss();
    int low_cycles = 0;
    for (int k = 0; k < 5; k++) begin
      toggle();
      for (int c = 0; c < 13; c++) begin
        tick_cycle();
        if (!locked) low_cycles++;
        compared++;
        if (out_bad()) begin
          mismatched++;
          $display("FAIL lock_loss cyc=%0d got l%b hp=%0d t%b, want l%b hp=%0d t%b",
                   cyc, locked, half_period, timeout, m_locked, m_half, m_to);
        end
      end
    end
    compared++;
    if (low_cycles == 0 || locked !== 1'b1 || half_period !== CW'(13)) begin
      mismatched++;
      $display("FAIL relock13 got low_cycles=%0d l%b hp=%0d, want >0, 1, 13",
               low_cycles, locked, half_period);
    end
  endtask

  task automatic test_timeout();
    int reg_c, pulses = 0, pulse_at = -1;
    toggle();
    reg_c = cyc + 3;
    for (int c = 0; c < 130; c++) begin
      tick_cycle();
      if (timeout) begin
        pulses++;
        pulse_at = cyc;
      end
      compared++;
      if (out_bad()) begin
        mismatched++;
        $display("FAIL timeout cyc=%0d got l%b t%b hp=%0d, want l%b t%b hp=%0d",
                 cyc, locked, timeout, half_period, m_locked, m_to, m_half);
      end
    end
    compared++;
    if (pulses != 1 || pulse_at != reg_c + TO || locked !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_once got %0d pulses at %0d l%b, want 1 at %0d l0",
               pulses, pulse_at, locked, reg_c + TO);
    end
  endtask

  task automatic test_simultaneous();
    int gaps[3] = '{10, 64, 10};
    int pulses = 0;
    for (int k = 0; k < 3; k++) begin
      toggle();
      for (int c = 0; c < gaps[k]; c++) begin
        tick_cycle();
        if (timeout) pulses++;
        compared++;
        if (out_bad()) begin
          mismatched++;
          $display("FAIL simult cyc=%0d got l%b t%b hp=%0d, want l%b t%b hp=%0d",
                   cyc, locked, timeout, half_period, m_locked, m_to, m_half);
        end
      end
    end
    compared++;
    if (pulses != 0 || half_period !== CW'(64)) begin
      mismatched++;
      $display("FAIL simult_edge got %0d timeouts hp=%0d, want 0 and 64", pulses, half_period);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) begin
      toggle();
      for (int c = 0; c < 10; c++) tick_cycle();
    end
    if (slow_clk !== 1'b1) begin
      toggle();
      for (int c = 0; c < 10; c++) tick_cycle();
    end
    compared++;
    if (locked !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_reset_lock got l%b want 1", locked);
    end
    rst = 1'b1;
    tick_cycle();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      compared++;
      if ({rise_tick, fall_tick, locked, timeout, half_period} !== {4'b0000, CW'(0)}) begin
        mismatched++;
        $display("FAIL reset_mid cyc=%0d got r%b f%b l%b t%b hp=%0d, want all zero",
                 cyc, rise_tick, fall_tick, locked, timeout, half_period);
      end
      tick_cycle();
    end
    for (int k = 0; k < 7; k++) begin
      toggle();
      for (int c = 0; c < 10; c++) begin
        tick_cycle();
        compared++;
        if (out_bad()) begin
          mismatched++;
          $display("FAIL relock cyc=%0d got l%b hp=%0d r%b f%b, want l%b hp=%0d r%b f%b",
                   cyc, locked, half_period, rise_tick, fall_tick,
                   m_locked, m_half, m_rise, m_fall);
        end
      end
    end
  endtask

  task automatic test_random();
    int base = 10;
    int gap;
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 11) == 0) base = int'($urandom_range(4, 30));
      if ($urandom_range(0, 39) == 0) gap = 70 + int'($urandom_range(0, 5));
      else if ($urandom_range(0, 9) == 0) gap = base + int'($urandom_range(3, 6));
      else gap = base + int'($urandom_range(0, 2)) - 1;
      toggle();
      for (int c = 0; c < gap; c++) begin
        tick_cycle();
        compared++;
        if (out_bad()) begin
          mismatched++;
          $display("FAIL random cyc=%0d got r%b f%b l%b t%b hp=%0d, want r%b f%b l%b t%b hp=%0d",
                   cyc, rise_tick, fall_tick, locked, timeout, half_period,
                   m_rise, m_fall, m_locked, m_to, m_half);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_acq();
    test_tolerance();
    test_lock_loss();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
